uart_rx_oversampled: RTL
========================

// Module: uart_rx_oversampled
// PURPOSE
//  Serial receiver for the 11-bit UART frame: start(0), 8 data bits LSB first, parity, stop(1).
//  Samples the line at OVERSAMPLE x baud from the system clock and checks parity and the stop bit.
//  Delivers each byte through a valid/ready holding register to the consumer (LED/display logic).
//  Sits directly downstream of the transmitter's tx line. Replaces the free-running uartclk-driven receiver.
// PARAMETERS
//  CLK_HZ      25_000_000  system clock frequency in Hz
//  BAUD        9600        line bit rate
//  OVERSAMPLE  16          samples per bit; must be even and >= 8
//  PARITY_ODD  0           0 = even parity (data+parity has an even number of ones); 1 = odd parity
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  rx          in   1  serial line, idles high, asynchronous to clk
//  rx_data     out  8  received byte; valid while rx_valid=1
//  rx_valid    out  1  byte held, waiting for the consumer
//  rx_ready    in   1  consumer accepts the byte on a cycle where rx_valid & rx_ready
//  parity_err  out  1  parity mismatch flag for the held byte; qualified by rx_valid
//  frame_err   out  1  stop bit sampled low for the held byte; qualified by rx_valid
//  overrun     out  1  one-cycle pulse: a completed frame was dropped because rx_valid was still 1
//  busy        out  1  FSM is not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; rx synchroniser flops 1; FSM IDLE; counters 0.
//  - rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//  - Tick: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer division. A divider counts 0..DIV-1 and
//    ticks when it equals DIV-1. A sub-bit counter (0..OVERSAMPLE-1) advances on each tick.
//  - IDLE: on rx_s==0, clear the divider and sub counter, then go to START.
//  - START: when sub == OVERSAMPLE/2-1 (mid-bit), sample rx_s.
//      - 1 -> glitch: go to IDLE; no output and no flags.
//      - 0 -> clear sub, go to DATA.
//  - DATA: sample when sub == OVERSAMPLE-1, shifting each bit into bit 7 (LSB first).
//    A 3-bit count moves to PARITY after 8 bits.
//  - PARITY: sample the parity bit at the same point.
//    perr = (^data ^ pbit) != PARITY_ODD.
//  - STOP: sample the stop bit at the same point; ferr = ~rx_s. Complete the frame on that tick.
//      - Stop bit was 1 -> go to IDLE.
//      - Stop bit was 0 -> go to WAIT_IDLE.
//  - WAIT_IDLE: stay until rx_s has been 1 for OVERSAMPLE consecutive ticks, then go to IDLE.
//    A break or stuck-low line never generates a frame.
//  - Completion, when rx_valid==0: on the next clk edge, rx_data/parity_err/frame_err load and
//    rx_valid=1. Latency is 1 clk after the stop-sample tick.
//    Frames with perr or ferr are still delivered, with their flag set.
//  - Completion, when rx_valid==1 and not accepted on the same cycle:
//      - the new frame is discarded;
//      - the held byte and flags are unchanged;
//      - overrun=1 for exactly one clk.
//  - Completion and accept on the same cycle: the new frame loads; rx_valid stays 1; no overrun.
//  - Handshake: rx_valid stays 1 and rx_data stays stable until a cycle with rx_ready=1.
//    rx_valid drops on the next edge. rx_ready=1 while rx_valid=0 has no effect.
//  - Reset mid-frame: the frame is abandoned and any held byte is lost. Reception restarts at the next falling edge.
//  - busy=1 in every state except IDLE.
// STRUCTURE
//  - uart_defs.vh, shared with the transmitter and the packet generator:
//      - FSM state encodings: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE;
//      - FRAME_BITS=11, DATA_BITS=8;
//      - parity-mode constants.
//  - Sub-module uart_baud_tick (params CLK_HZ, BAUD, OVERSAMPLE; ports clk, rst_n, clear, tick).
//    Reused by the transmitter.
//  - Receiver FSM, shift register and output holding register live in this module.
// TESTING  (CLK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, 160 clk per bit)
//  1. Send 0xA5 with parity 0 and stop 1, rx_ready=1.
//     -> rx_valid high exactly 1 clk; rx_data=0xA5; parity_err=0; frame_err=0.
//  2. Send 0x01 with parity 0 (wrong).
//     -> rx_data=0x01, parity_err=1, frame_err=0.
//  3. Send 0x3C with stop 0, line held low 5 bits, then high.
//     -> one frame: rx_data=0x3C, frame_err=1. No further rx_valid until a frame starts after 16 high ticks.
//  4. Idle line pulled low for 60 clk (< half bit), then high.
//     -> no rx_valid; busy returns to 0; the next frame 0x7E is received correctly.
//  5. rx_ready=0; send 0x11 then 0x22.
//     -> rx_data stays 0x11; overrun pulses 1 clk at the second stop sample.
//     -> rx_ready=1 then drops rx_valid the next clk.
//  6. Assert rst_n=0 during data bit 3, release, then send 0x5A.
//     -> all outputs 0 during reset; 0x5A is received with no errors.

Source files
------------

// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART definitions: frame geometry, parity modes and receiver FSM states.
package uart_rx_oversampled_pkg;

    localparam int unsigned FrameBits = 11;
    localparam int unsigned DataBits  = 8;

    localparam logic ParityEven = 1'b0;
    localparam logic ParityOdd  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_e;

    // True when data plus parity bit do not match the selected parity mode.
    function automatic logic parity_mismatch(input logic [DataBits-1:0] data,
                                             input logic                pbit,
                                             input logic                odd);
        return ((^data) ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every CLK_HZ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick #(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned DivRaw = CLK_HZ / (BAUD * OVERSAMPLE);
    // Guard against a zero divisor from an out-of-range parameter set.
    localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
    localparam int unsigned CntW   = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q;
    logic            at_last;

    // Tick decode; suppressed while the counter is being cleared.
    always_comb begin
        at_last = (cnt_q == LastCnt);
        tick_o  = at_last && !clear_i;
    end

    // Divider counts 0..Div-1 and restarts on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i || at_last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver (start, 8 data LSB first, parity, stop) with a
// valid/ready holding register, parity/framing flags and overrun pulse.
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                parity_err_o,
    output logic                frame_err_o,
    output logic                overrun_o,
    output logic                busy_o
);

    localparam int unsigned     SubW       = $clog2(OVERSAMPLE);
    localparam logic [SubW-1:0] SubMid     = SubW'(OVERSAMPLE / 2 - 1);
    localparam logic [SubW-1:0] SubLast    = SubW'(OVERSAMPLE - 1);
    localparam logic            ParityMode = (PARITY_ODD != 0) ? ParityOdd : ParityEven;

    logic                rx_meta_q, rx_s_q;
    rx_state_e           state_q;
    logic [SubW-1:0]     sub_q, sub_wrap;
    logic [2:0]          bit_cnt_q;
    logic [DataBits-1:0] shift_q;
    logic                perr_q;
    logic                busy_q;
    logic [DataBits-1:0] rx_data_q;
    logic                rx_valid_q, parity_err_q, frame_err_q, overrun_q;
    logic                tick, clear, accept;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Divider restart aligns sub-bit phase to the detected falling edge.
    always_comb begin
        clear    = (state_q == StIdle) && !rx_s_q;
        accept   = rx_valid_q && rx_ready_i;
        sub_wrap = (sub_q == SubLast) ? '0 : sub_q + SubW'(1);
    end

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear),
        .tick_o (tick)
    );

    // Receiver FSM, shift register and output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sub_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            // A completing frame below may re-assert valid in the same cycle.
            if (accept) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        sub_q   <= '0;
                        state_q <= StStart;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (tick) begin
                        if (sub_q == SubMid) begin
                            sub_q <= '0;
                            if (rx_s_q) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end else begin
                                bit_cnt_q <= '0;
                                state_q   <= StData;
                            end
                        end else begin
                            sub_q <= sub_q + SubW'(1);
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        sub_q <= sub_wrap;
                        if (sub_q == SubLast) begin
                            shift_q   <= {rx_s_q, shift_q[DataBits-1:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'(DataBits - 1)) begin
                                state_q <= StParity;
                            end
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        sub_q <= sub_wrap;
                        if (sub_q == SubLast) begin
                            perr_q  <= parity_mismatch(shift_q, rx_s_q, ParityMode);
                            state_q <= StStop;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        sub_q <= sub_wrap;
                        if (sub_q == SubLast) begin
                            // Load when the register is free or being emptied this cycle.
                            if (!rx_valid_q || rx_ready_i) begin
                                rx_data_q    <= shift_q;
                                parity_err_q <= perr_q;
                                frame_err_q  <= ~rx_s_q;
                                rx_valid_q   <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            if (rx_s_q) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end else begin
                                sub_q   <= '0;
                                state_q <= StWaitIdle;
                            end
                        end
                    end
                end
                StWaitIdle: begin
                    // sub_q counts consecutive high ticks here.
                    if (tick) begin
                        if (!rx_s_q) begin
                            sub_q <= '0;
                        end else if (sub_q == SubLast) begin
                            sub_q   <= '0;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            sub_q <= sub_q + SubW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs.
    always_comb begin
        rx_data_o    = rx_data_q;
        rx_valid_o   = rx_valid_q;
        parity_err_o = parity_err_q;
        frame_err_o  = frame_err_q;
        overrun_o    = overrun_q;
        busy_o       = busy_q;
    end

endmodule
